// File: rtl/seq_prefix_subtractor.sv
// Multi-cycle wide subtractor: diff = a - b - bin, one SLICE-bit
// Sklansky prefix slice per cycle with the carry chained between slices.

// One SLICE-bit Sklansky parallel-prefix adder with carry-in.
module sps_sklansky_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] i_x,
  input  logic [SLICE-1:0] i_y,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_s,
  output logic             o_cout
);
  localparam int LV = $clog2(SLICE);

  // Level l holds group generate/propagate spanning from the current
  // block start up to bit i; after LV levels every group reaches bit 0.
  logic [SLICE-1:0] w_g [LV+1];
  logic [SLICE-1:0] w_p [LV+1];
  logic [SLICE:0]   w_c;

  assign w_g[0] = i_x & i_y;
  assign w_p[0] = i_x ^ i_y;

  genvar l, i;
  generate
    for (l = 0; l < LV; l++) begin : g_lvl
      for (i = 0; i < SLICE; i++) begin : g_bit
        if (((i >> l) & 1) == 1) begin : g_op
          // Combine with the last bit of the lower half of this block.
          localparam int J = ((i >> l) << l) - 1;
          assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][J]);
          assign w_p[l+1][i] = w_p[l][i] & w_p[l][J];
        end else begin : g_pass
          assign w_g[l+1][i] = w_g[l][i];
          assign w_p[l+1][i] = w_p[l][i];
        end
      end
    end
  endgenerate

  // Carry into bit i+1 folds the slice carry-in through the prefix (0..i).
  assign w_c[0] = i_cin;
  generate
    for (i = 0; i < SLICE; i++) begin : g_carry
      assign w_c[i+1] = w_g[LV][i] | (w_p[LV][i] & i_cin);
    end
  endgenerate

  assign o_s    = w_p[0] ^ w_c[SLICE-1:0];
  assign o_cout = w_c[SLICE];
endmodule

module seq_prefix_subtractor #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_carry, r_bout, r_ovf, r_out_valid;

  logic [SLICE-1:0] w_x, w_y, w_s;
  logic             w_cout;

  // Subtraction as a + ~b + ~bin on the currently selected slice.
  assign w_x = r_a[int'(r_cnt)*SLICE +: SLICE];
  assign w_y = ~r_b[int'(r_cnt)*SLICE +: SLICE];

  sps_sklansky_slice #(.SLICE(SLICE)) u_slice (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // Handshake FSM: latch operands, walk slices LSB first, hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_carry     <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ~bin;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_diff[int'(r_cnt)*SLICE +: SLICE] <= w_s;
          r_carry <= w_cout;
          if (r_cnt == LAST) begin
            // Final slice: w_s[SLICE-1] is the result sign bit.
            r_bout      <= ~w_cout;
            r_ovf       <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                           (w_s[SLICE-1] != r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
endmodule

// File: doc/seq_prefix_subtractor.md
Name: seq_prefix_subtractor

Overview:
- Multi-cycle, handshaked wide subtractor: computes diff = A - B - bin on WIDTH-bit operands.
- Iterates one SLICE-bit Sklansky parallel-prefix slice per cycle, chaining the carry between slices.
- Complements the combinational prefix adders in the arithmetic library. Used where wide subtraction must trade latency for area.

Parameters:
- WIDTH, 64, operand/result width; must be an integer multiple of SLICE.
- SLICE, 16, bits processed per cycle; power of 2, at least 2. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  A - B - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 when unsigned A < B + bin
- ovf  output  1  two's-complement signed overflow of the subtraction

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, slice counter=0, out_valid=0, diff=0, bout=0, ovf=0, in_ready=1 (in_ready is decoded from state).
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and bin, set carry=~bin and counter=0, then go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle, slice k=counter computes {c_out, s} = a[k] + ~b[k] + carry using an internal SLICE-bit Sklansky prefix network (p=x^y, g=x&y, log2(SLICE) prefix levels). Write s into diff[k], update carry=c_out, and increment counter. After slice NSLICE-1 is written, go to DONE.
  - DONE: out_valid=1; diff, bout and ovf stay stable. On out_ready, go to IDLE.
- Latency: operands accepted at edge t produce out_valid=1 after edge t+NSLICE (4 cycles at the defaults).
- Throughput: one operation per NSLICE+2 cycles at most. There is no same-cycle re-accept; in_ready rises the cycle after the DONE handshake.
- bout = ~carry after the final slice.
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
- diff is partially updated during CALC. Downstream must sample only when out_valid=1.
- Inputs a, b and bin are ignored outside the IDLE handshake; changes during CALC/DONE have no effect.
- in_valid held high through DONE does not start a new operation until the block returns to IDLE.
- Reset asserted in any state immediately forces the reset values; an in-flight operation is discarded and no out_valid pulse occurs.
- out_ready asserted outside DONE is ignored.
- Counter width is max(1, clog2(NSLICE)). The counter does not wrap during normal operation; it is reloaded on accept.

Test Plan:
1. Borrow propagation across a slice boundary: a=0x0000_0000_0001_0000, b=0x1, bin=0 -> after 4 cycles diff=0x0000_0000_0000_FFFF, bout=0, ovf=0.
2. Full-width borrow: a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0. Separately, a=5, b=3, bin=1 -> diff=1, bout=0.
3. Signed overflow: a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0. Separately, a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, ovf=1, bout=1.
4. Backpressure: out_ready=0 for 3 cycles after out_valid rises -> diff, bout and ovf are held; in_ready=0 throughout; the result retires on the out_ready pulse; in_ready=1 on the next cycle.
5. Back-to-back and input churn: in_valid held high with new a and b every cycle -> exactly one accept per IDLE visit; results match the operands latched at each accept.
6. Reset mid-CALC: assert rst at counter=2 -> out_valid=0, diff=0 immediately. After release, in_ready=1, and a fresh a=0x1234_5678_9ABC_DEF0, b=0x0FED_CBA9_8765_4321 gives diff=0x0246_8ACF_1357_9BCF, bout=0.
